// File: rtl/vga_pkg.sv
// Shared types, default 640x480 timing and frame-size helpers for the VGA sync generator.
package vga_pkg;

    typedef enum logic [0:0] {
        SYNC = 1'b0,
        DISP = 1'b1
    } vga_state_t;

    localparam int DEF_HD = 640;
    localparam int DEF_HF = 16;
    localparam int DEF_HB = 48;
    localparam int DEF_HR = 96;
    localparam int DEF_VD = 480;
    localparam int DEF_VF = 10;
    localparam int DEF_VB = 33;
    localparam int DEF_VR = 2;

    function automatic int calc_ht(input int hd, input int hf, input int hb, input int hr);
        return hd + hf + hb + hr;
    endfunction

    function automatic int calc_vt(input int vd, input int vf, input int vb, input int vr);
        return vd + vf + vb + vr;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running x/y scan counters with display-window and raw sync-window decode.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int HD = DEF_HD,
    parameter int HF = DEF_HF,
    parameter int HB = DEF_HB,
    parameter int HR = DEF_HR,
    parameter int VD = DEF_VD,
    parameter int VF = DEF_VF,
    parameter int VB = DEF_VB,
    parameter int VR = DEF_VR,
    parameter int CW = 11
) (
    input  logic          clk,
    input  logic          reset,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          scan_end,
    output logic          video_on,
    output logic          h_active,
    output logic          v_active
);

    localparam int HT = calc_ht(HD, HF, HB, HR);
    localparam int VT = calc_vt(VD, VF, VB, VR);

    localparam logic [CW-1:0] X_LAST     = CW'(HT - 1);
    localparam logic [CW-1:0] Y_LAST     = CW'(VT - 1);
    localparam logic [CW-1:0] X_DISP     = CW'(HD);
    localparam logic [CW-1:0] Y_DISP     = CW'(VD);
    localparam logic [CW-1:0] HS_START   = CW'(HD + HF);
    localparam logic [CW-1:0] HS_END     = CW'(HD + HF + HR - 1);
    localparam logic [CW-1:0] VS_START   = CW'(VD + VF);
    localparam logic [CW-1:0] VS_END     = CW'(VD + VF + VR - 1);

    logic [CW-1:0] x_reg;
    logic [CW-1:0] y_reg;
    logic          x_last;
    logic          y_last;

    assign x_last = (x_reg == X_LAST);
    assign y_last = (y_reg == Y_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (x_last) begin
            x_reg <= '0;
            y_reg <= y_last ? '0 : y_reg + CW'(1);
        end else begin
            x_reg <= x_reg + CW'(1);
        end
    end

    assign x        = x_reg;
    assign y        = y_reg;
    assign scan_end = x_last && y_last;
    assign video_on = (x_reg < X_DISP) && (y_reg < Y_DISP);
    assign h_active = (x_reg >= HS_START) && (x_reg <= HS_END);
    assign v_active = (y_reg >= VS_START) && (y_reg <= VS_END);

endmodule

// File: rtl/vga_sync_gen.sv
// Parametrised VGA synchroniser: locks a valid/ready pixel stream to the scan on its
// start-of-frame bit, fills starved pixels, and drops back to SYNC on a misplaced start.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int            CD       = 12,
    parameter int            HD       = DEF_HD,
    parameter int            HF       = DEF_HF,
    parameter int            HB       = DEF_HB,
    parameter int            HR       = DEF_HR,
    parameter int            VD       = DEF_VD,
    parameter int            VF       = DEF_VF,
    parameter int            VB       = DEF_VB,
    parameter int            VR       = DEF_VR,
    parameter bit            HS_POL   = 1'b0,
    parameter bit            VS_POL   = 1'b0,
    parameter logic [CD-1:0] UF_COLOR = '0,
    parameter int            CW       = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CD:0]   vga_si_data,
    input  logic          vga_si_valid,
    output logic          vga_si_ready,
    output logic          hsync,
    output logic          vsync,
    output logic [CD-1:0] rgb,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          frame_start,
    output logic          underflow,
    output logic          resync_err,
    output logic [15:0]   uf_count
);

    localparam logic [CW-1:0] X_LAST_DISP = CW'(HD - 1);
    localparam logic [CW-1:0] Y_LAST_DISP = CW'(VD - 1);

    logic [CW-1:0] x_cnt;
    logic [CW-1:0] y_cnt;
    logic          scan_end;
    logic          video_on;
    logic          h_active;
    logic          v_active;

    vga_timing_gen #(
        .HD(HD), .HF(HF), .HB(HB), .HR(HR),
        .VD(VD), .VF(VF), .VB(VB), .VR(VR),
        .CW(CW)
    ) u_timing (
        .clk      (clk),
        .reset    (reset),
        .x        (x_cnt),
        .y        (y_cnt),
        .scan_end (scan_end),
        .video_on (video_on),
        .h_active (h_active),
        .v_active (v_active)
    );

    vga_state_t    state_reg, state_next;
    logic [CD-1:0] rgb_reg, rgb_next;
    logic          frame_start_reg, frame_start_next;
    logic          underflow_reg, underflow_next;
    logic          resync_err_reg, resync_err_next;
    logic [15:0]   uf_count_reg, uf_count_next;
    logic          hsync_reg;
    logic          vsync_reg;
    logic          ready;

    logic          sof;
    logic [CD-1:0] pix_colour;
    logic          at_origin;
    logic          last_pixel;

    assign sof        = vga_si_data[0];
    assign pix_colour = vga_si_data[CD:1];
    assign at_origin  = (x_cnt == '0) && (y_cnt == '0);
    assign last_pixel = (x_cnt == X_LAST_DISP) && (y_cnt == Y_LAST_DISP);

    always_comb begin
        state_next       = state_reg;
        ready            = 1'b0;
        rgb_next         = '0;
        frame_start_next = 1'b0;
        underflow_next   = 1'b0;
        resync_err_next  = 1'b0;
        uf_count_next    = uf_count_reg;
        case (state_reg)
            SYNC: begin
                // Non-start words are drained; a start word waits for the frame boundary.
                ready = vga_si_valid && !sof;
                if (scan_end && vga_si_valid && sof) begin
                    state_next = DISP;
                end
            end
            DISP: begin
                if (video_on) begin
                    frame_start_next = at_origin;
                    if (vga_si_valid && sof && !at_origin) begin
                        // Leave the start word unconsumed so it opens the next frame.
                        resync_err_next = 1'b1;
                        state_next      = SYNC;
                    end else if (vga_si_valid) begin
                        ready    = 1'b1;
                        rgb_next = pix_colour;
                    end else begin
                        rgb_next       = UF_COLOR;
                        underflow_next = 1'b1;
                        if (uf_count_reg != 16'hFFFF) begin
                            uf_count_next = uf_count_reg + 16'd1;
                        end
                    end
                end
                if (last_pixel) begin
                    state_next = SYNC;
                end
            end
            default: state_next = SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= SYNC;
            rgb_reg         <= '0;
            frame_start_reg <= 1'b0;
            underflow_reg   <= 1'b0;
            resync_err_reg  <= 1'b0;
            uf_count_reg    <= '0;
            hsync_reg       <= ~HS_POL;
            vsync_reg       <= ~VS_POL;
        end else begin
            state_reg       <= state_next;
            rgb_reg         <= rgb_next;
            frame_start_reg <= frame_start_next;
            underflow_reg   <= underflow_next;
            resync_err_reg  <= resync_err_next;
            uf_count_reg    <= uf_count_next;
            hsync_reg       <= h_active ? HS_POL : ~HS_POL;
            vsync_reg       <= v_active ? VS_POL : ~VS_POL;
        end
    end

    assign vga_si_ready = ready;
    assign hsync        = hsync_reg;
    assign vsync        = vsync_reg;
    assign rgb          = rgb_reg;
    assign x            = x_cnt;
    assign y            = y_cnt;
    assign frame_start  = frame_start_reg;
    assign underflow    = underflow_reg;
    assign resync_err   = resync_err_reg;
    assign uf_count     = uf_count_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen on a 14x7 toy timing: reset, sync shape, lock, underflow,
// resync and mid-frame reset, with expected values derived by hand from the timing table.
module tb_vga_sync_gen;

    localparam int CD = 12;
    localparam int CW = 11;
    localparam int HT = 14;
    localparam int VT = 7;
    localparam int HD = 8;
    localparam int VD = 4;
    localparam logic [CD-1:0] UFC = 12'hF0F;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CD:0]   data = '0;
    logic          valid = 1'b0;
    logic          ready;
    logic          hsync, vsync;
    logic [CD-1:0] rgb;
    logic [CW-1:0] x, y;
    logic          frame_start, underflow, resync_err;
    logic [15:0]   uf_count;

    logic          i_ready, i_hsync, i_vsync, i_fs, i_uf, i_re;
    logic [CD-1:0] i_rgb;
    logic [CW-1:0] i_x, i_y;
    logic [15:0]   i_ufc;

    int checks = 0;
    int failures = 0;
    int bx, by;

    always #5 clk = ~clk;

    vga_sync_gen #(
        .CD(CD), .HD(8), .HF(2), .HB(2), .HR(2), .VD(4), .VF(1), .VB(1), .VR(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .UF_COLOR(UFC), .CW(CW)
    ) dut (
        .clk(clk), .reset(reset), .vga_si_data(data), .vga_si_valid(valid),
        .vga_si_ready(ready), .hsync(hsync), .vsync(vsync), .rgb(rgb), .x(x), .y(y),
        .frame_start(frame_start), .underflow(underflow), .resync_err(resync_err),
        .uf_count(uf_count)
    );

    vga_sync_gen #(
        .CD(CD), .HD(8), .HF(2), .HB(2), .HR(2), .VD(4), .VF(1), .VB(1), .VR(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .UF_COLOR(UFC), .CW(CW)
    ) dut_inv (
        .clk(clk), .reset(reset), .vga_si_data('0), .vga_si_valid(1'b0),
        .vga_si_ready(i_ready), .hsync(i_hsync), .vsync(i_vsync), .rgb(i_rgb), .x(i_x), .y(i_y),
        .frame_start(i_fs), .underflow(i_uf), .resync_err(i_re), .uf_count(i_ufc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CD-1:0] colour_of(input int cx, input int cy);
        return 12'h800 | 12'(cy << 4) | 12'(cx);
    endfunction

    task automatic advance();
        bx++;
        if (bx == HT) begin
            bx = 0;
            by = (by + 1) % VT;
        end
    endtask

    // Stream non-start words from (bx,by) up to but not including (tx,ty).
    task automatic stream_until(input int tx, input int ty, input bit uf_en);
        bit uf, von;
        logic [CD-1:0] col;
        while (!(bx == tx && by == ty)) begin
            uf  = uf_en && (by == 1) && (bx == 3 || bx == 4);
            von = (bx < HD) && (by < VD);
            col = colour_of(bx, by);
            if (uf) begin
                valid = 1'b0;
            end else begin
                valid = 1'b1;
                data  = {col, 1'b0};
            end
            #1;
            chk($sformatf("ready(%0d,%0d)", bx, by), 32'(ready), 32'(!uf && von));
            step();
            chk($sformatf("rgb(%0d,%0d)", bx, by), 32'(rgb), uf ? 32'(UFC) : (von ? 32'(col) : 32'd0));
            chk($sformatf("underflow(%0d,%0d)", bx, by), 32'(underflow), 32'(uf));
            advance();
            chk($sformatf("pos(%0d,%0d)", bx, by), 32'({x, y}), 32'({11'(bx), 11'(by)}));
        end
    endtask

    initial begin
        int hs_low, hs_first, vs_low, vs_first, ihs_high, ivs_high, pos_err, misc_err, n;

        // Reset held for three edges
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hsync", 32'(hsync), 32'd1);
        chk("rst_vsync", 32'(vsync), 32'd1);
        chk("rst_rgb", 32'(rgb), 32'd0);
        chk("rst_xy", 32'({x, y}), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_flags", 32'({frame_start, underflow, resync_err, uf_count}), 32'd0);
        chk("rst_inv_sync", 32'({i_hsync, i_vsync}), 32'd0);
        reset = 1'b0;

        // Free-run one frame with no stream
        hs_low = 0; hs_first = -1; vs_low = 0; vs_first = -1;
        ihs_high = 0; ivs_high = 0; pos_err = 0; misc_err = 0;
        for (int i = 1; i <= HT * VT; i++) begin
            step();
            if (x !== 11'(i % HT) || y !== 11'((i / HT) % VT)) pos_err++;
            if (hsync === 1'b0) begin hs_low++; if (hs_first < 0) hs_first = i; end
            if (vsync === 1'b0) begin vs_low++; if (vs_first < 0) vs_first = i; end
            if (i_hsync === 1'b1) ihs_high++;
            if (i_vsync === 1'b1) ivs_high++;
            if (rgb !== '0 || ready !== 1'b0 || i_x !== x || i_y !== y) misc_err++;
        end
        chk("sync_pos_errors", 32'(pos_err), 32'd0);
        chk("hsync_low_cycles", 32'(hs_low), 32'd14);
        chk("hsync_first_low", 32'(hs_first), 32'd11);
        chk("vsync_low_cycles", 32'(vs_low), 32'd14);
        chk("vsync_first_low", 32'(vs_first), 32'd71);
        chk("inv_hsync_high", 32'(ihs_high), 32'd14);
        chk("inv_vsync_high", 32'(ivs_high), 32'd14);
        chk("sync_idle_errors", 32'(misc_err), 32'd0);
        chk("frame_period_xy", 32'({x, y}), 32'd0);
        chk("inv_idle_outputs", 32'({i_rgb, i_fs, i_uf, i_re, i_ready, i_ufc}), 32'd0);

        // Flush non-start words, then hold a start word until scan_end
        valid = 1'b1;
        data = {12'h123, 1'b0}; #1; chk("flush_ready0", 32'(ready), 32'd1); step();
        data = {12'h456, 1'b0}; #1; chk("flush_ready1", 32'(ready), 32'd1); step();
        data = {12'h789, 1'b0}; #1; chk("flush_ready2", 32'(ready), 32'd1); step();
        data = {12'hABC, 1'b1}; #1; chk("hold_ready", 32'(ready), 32'd0);
        n = 0; misc_err = 0;
        while (!(x == 11'(HT - 1) && y == 11'(VT - 1)) && n < 200) begin
            if (ready !== 1'b0 || rgb !== '0) misc_err++;
            step();
            n++;
        end
        chk("hold_cycles", 32'(n), 32'd94);
        chk("hold_errors", 32'(misc_err), 32'd0);
        chk("scan_end_ready", 32'(ready), 32'd0);
        step();
        chk("lock_xy", 32'({x, y}), 32'd0);
        chk("lock_ready", 32'(ready), 32'd1);
        step();
        chk("lock_rgb", 32'(rgb), 32'hABC);
        chk("lock_frame_start", 32'(frame_start), 32'd1);

        // Stream with a 2-pixel underflow at (3,1)
        bx = 1; by = 0;
        stream_until(5, 2, 1'b1);
        chk("uf_count", 32'(uf_count), 32'd2);

        // Start word in mid-frame at (5,2)
        data = {12'h5A5, 1'b1}; valid = 1'b1; #1;
        chk("resync_ready", 32'(ready), 32'd0);
        step(); advance();
        chk("resync_err", 32'(resync_err), 32'd1);
        chk("resync_rgb", 32'(rgb), 32'd0);
        misc_err = 0; n = 0;
        while (!(bx == HT - 1 && by == VT - 1) && n < 200) begin
            if (ready !== 1'b0) misc_err++;
            step(); advance(); n++;
            if (rgb !== '0 || resync_err !== 1'b0 || underflow !== 1'b0) misc_err++;
        end
        chk("post_resync_errors", 32'(misc_err), 32'd0);
        chk("post_resync_ready", 32'(ready), 32'd0);
        step(); advance();
        chk("relock_xy", 32'({x, y}), 32'd0);
        chk("relock_ready", 32'(ready), 32'd1);
        step(); advance();
        chk("relock_rgb", 32'(rgb), 32'h5A5);
        chk("relock_frame_start", 32'(frame_start), 32'd1);

        // Mid-frame reset at (4,2) while a start word is offered
        stream_until(4, 2, 1'b0);
        chk("pre_reset_uf_count", 32'(uf_count), 32'd2);
        reset = 1'b1;
        data = {12'h777, 1'b1}; valid = 1'b1;
        step();
        chk("mrst_xy", 32'({x, y}), 32'd0);
        chk("mrst_uf_count", 32'(uf_count), 32'd0);
        chk("mrst_sync", 32'({hsync, vsync}), 32'h3);
        chk("mrst_flags", 32'({rgb, frame_start, underflow, resync_err}), 32'd0);
        reset = 1'b0; #1;
        chk("mrst_state_sync", 32'(ready), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
